// File: rtl/fsm_pkg.sv
// Shared constants for the FSM control threshold interface.
// Contents: FIFO index constants, umbrales_I field slices, threshold widths
// and default FIFO depths.
package fsm_pkg;

  localparam int unsigned NUM_FIFOS = 5;

  // Bit position of each FIFO on every 5-bit strobe/flag vector.
  localparam int unsigned IDX_MF  = 0;
  localparam int unsigned IDX_VC0 = 1;
  localparam int unsigned IDX_VC1 = 2;
  localparam int unsigned IDX_D0  = 3;
  localparam int unsigned IDX_D1  = 4;

  // Field layout of the packed 14-bit threshold word.
  localparam int unsigned UMB_W       = 14;
  localparam int unsigned UMB_MF_MSB  = 13;
  localparam int unsigned UMB_MF_LSB  = 12;
  localparam int unsigned UMB_VC0_MSB = 11;
  localparam int unsigned UMB_VC0_LSB = 8;
  localparam int unsigned UMB_VC1_MSB = 7;
  localparam int unsigned UMB_VC1_LSB = 4;
  localparam int unsigned UMB_D0_MSB  = 3;
  localparam int unsigned UMB_D0_LSB  = 2;
  localparam int unsigned UMB_D1_MSB  = 1;
  localparam int unsigned UMB_D1_LSB  = 0;

  localparam int unsigned TW_MF = UMB_MF_MSB - UMB_MF_LSB + 1;
  localparam int unsigned TW_VC = UMB_VC0_MSB - UMB_VC0_LSB + 1;
  localparam int unsigned TW_D  = UMB_D0_MSB - UMB_D0_LSB + 1;

  localparam int unsigned DEFAULT_DEPTH_MF = 4;
  localparam int unsigned DEFAULT_DEPTH_VC = 16;
  localparam int unsigned DEFAULT_DEPTH_D  = 4;

endpackage

// File: rtl/fifo_occ_counter.sv
// Occupancy tracker for a single FIFO.
// Keeps the entry count from push/pop strobes, a latched threshold and a
// sticky overflow/underflow error bit, and derives the status flags.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   thr_in, thr_load threshold value and its latch strobe
//   push, pop        write/read strobes of the tracked FIFO
//   error_clr        synchronous clear of the sticky error
//   empty, full, almost_empty, almost_full, error  status outputs
module fifo_occ_counter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] thr_in,
  input  logic          thr_load,
  input  logic          push,
  input  logic          pop,
  input  logic          error_clr,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Wide enough to hold count + threshold without wrapping.
  localparam int unsigned SW = ((CW > TW) ? CW : TW) + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] thr_q, thr_d;
  logic          error_q, error_d;
  logic          err_set;

  always_comb begin
    count_d = count_q;
    err_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == DepthC) err_set = 1'b1;
        else                   count_d = count_q + CW'(1);
      end
      2'b01: begin
        if (count_q == '0) err_set = 1'b1;
        else               count_d = count_q - CW'(1);
      end
      2'b11: begin
        // Empty FIFO: the push lands, the pop has nothing to read.
        if (count_q == '0) begin
          count_d = CW'(1);
          err_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    thr_d = thr_load ? thr_in : thr_q;
    // A new error takes priority over a clear on the same edge.
    error_d = err_set ? 1'b1 : (error_clr ? 1'b0 : error_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      thr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      thr_q   <= thr_d;
      error_q <= error_d;
    end
  end

  logic [SW-1:0] count_ext, thr_ext;

  always_comb begin
    count_ext    = SW'(count_q);
    thr_ext      = SW'(thr_q);
    empty        = (count_q == '0);
    full         = (count_q == DepthC);
    almost_empty = (count_ext <= thr_ext);
    // count >= depth - thr, rearranged so a large threshold cannot underflow.
    almost_full  = ((count_ext + thr_ext) >= SW'(DEPTH));
    error        = error_q;
  end

endmodule

// File: rtl/fifo_umbral_monitor.sv
// Responder side of the FSM control threshold interface.
// Tracks occupancy of the MF, VC0, VC1, D0 and D1 FIFOs and reports
// empty/full/almost flags and sticky errors per FIFO (bit order MF..D1).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   umbrales_I        packed thresholds, latched when umbral_load is high
//   push, pop         per-FIFO strobes
//   error_clr         clears all sticky error bits
//   FIFO_empty, FIFO_full, almost_empty, almost_full, FIFO_error  flags
//   FIFO_pause        any FIFO almost full
module fifo_umbral_monitor
  import fsm_pkg::*;
#(
  parameter int unsigned DEPTH_MF = DEFAULT_DEPTH_MF,
  parameter int unsigned DEPTH_VC = DEFAULT_DEPTH_VC,
  parameter int unsigned DEPTH_D  = DEFAULT_DEPTH_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [UMB_W-1:0] umbrales_I,
  input  logic             umbral_load,
  input  logic [4:0]       push,
  input  logic [4:0]       pop,
  input  logic             error_clr,
  output logic [4:0]       FIFO_empty,
  output logic [4:0]       FIFO_full,
  output logic [4:0]       almost_empty,
  output logic [4:0]       almost_full,
  output logic [4:0]       FIFO_error,
  output logic             FIFO_pause
);

  fifo_occ_counter #(.DEPTH(DEPTH_MF), .TW(TW_MF)) u_mf (
    .clk          (clk),
    .reset        (reset),
    .thr_in       (umbrales_I[UMB_MF_MSB:UMB_MF_LSB]),
    .thr_load     (umbral_load),
    .push         (push[IDX_MF]),
    .pop          (pop[IDX_MF]),
    .error_clr    (error_clr),
    .empty        (FIFO_empty[IDX_MF]),
    .full         (FIFO_full[IDX_MF]),
    .almost_empty (almost_empty[IDX_MF]),
    .almost_full  (almost_full[IDX_MF]),
    .error        (FIFO_error[IDX_MF])
  );

  fifo_occ_counter #(.DEPTH(DEPTH_VC), .TW(TW_VC)) u_vc0 (
    .clk          (clk),
    .reset        (reset),
    .thr_in       (umbrales_I[UMB_VC0_MSB:UMB_VC0_LSB]),
    .thr_load     (umbral_load),
    .push         (push[IDX_VC0]),
    .pop          (pop[IDX_VC0]),
    .error_clr    (error_clr),
    .empty        (FIFO_empty[IDX_VC0]),
    .full         (FIFO_full[IDX_VC0]),
    .almost_empty (almost_empty[IDX_VC0]),
    .almost_full  (almost_full[IDX_VC0]),
    .error        (FIFO_error[IDX_VC0])
  );

  fifo_occ_counter #(.DEPTH(DEPTH_VC), .TW(TW_VC)) u_vc1 (
    .clk          (clk),
    .reset        (reset),
    .thr_in       (umbrales_I[UMB_VC1_MSB:UMB_VC1_LSB]),
    .thr_load     (umbral_load),
    .push         (push[IDX_VC1]),
    .pop          (pop[IDX_VC1]),
    .error_clr    (error_clr),
    .empty        (FIFO_empty[IDX_VC1]),
    .full         (FIFO_full[IDX_VC1]),
    .almost_empty (almost_empty[IDX_VC1]),
    .almost_full  (almost_full[IDX_VC1]),
    .error        (FIFO_error[IDX_VC1])
  );

  fifo_occ_counter #(.DEPTH(DEPTH_D), .TW(TW_D)) u_d0 (
    .clk          (clk),
    .reset        (reset),
    .thr_in       (umbrales_I[UMB_D0_MSB:UMB_D0_LSB]),
    .thr_load     (umbral_load),
    .push         (push[IDX_D0]),
    .pop          (pop[IDX_D0]),
    .error_clr    (error_clr),
    .empty        (FIFO_empty[IDX_D0]),
    .full         (FIFO_full[IDX_D0]),
    .almost_empty (almost_empty[IDX_D0]),
    .almost_full  (almost_full[IDX_D0]),
    .error        (FIFO_error[IDX_D0])
  );

  fifo_occ_counter #(.DEPTH(DEPTH_D), .TW(TW_D)) u_d1 (
    .clk          (clk),
    .reset        (reset),
    .thr_in       (umbrales_I[UMB_D1_MSB:UMB_D1_LSB]),
    .thr_load     (umbral_load),
    .push         (push[IDX_D1]),
    .pop          (pop[IDX_D1]),
    .error_clr    (error_clr),
    .empty        (FIFO_empty[IDX_D1]),
    .full         (FIFO_full[IDX_D1]),
    .almost_empty (almost_empty[IDX_D1]),
    .almost_full  (almost_full[IDX_D1]),
    .error        (FIFO_error[IDX_D1])
  );

  assign FIFO_pause = |almost_full;

endmodule
